// File: rtl/exe_hazard_fwd_ctrl_if.sv
// Bundle between ID decode and the EXE hazard/forwarding controller.
// The master side is the ID stage; the slave side is the controller.
interface exe_hazard_fwd_ctrl_if #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic              forward_en;
   logic              mem_freeze;
   logic              flush;
   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic              id_src1_used;
   logic [REG_AW-1:0] id_src2;
   logic              id_src2_used;
   logic [REG_AW-1:0] id_dest;
   logic              id_wb_en;
   logic              id_mem_r;
   logic              hazard_stall;
   logic [1:0]        sel_src1;
   logic [1:0]        sel_src2;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      output forward_en, mem_freeze, flush, id_valid,
      output id_src1, id_src1_used, id_src2, id_src2_used,
      output id_dest, id_wb_en, id_mem_r,
      input  hazard_stall, sel_src1, sel_src2, stall_cycles
   );

   modport slave (
      input  forward_en, mem_freeze, flush, id_valid,
      input  id_src1, id_src1_used, id_src2, id_src2_used,
      input  id_dest, id_wb_en, id_mem_r,
      output hazard_stall, sel_src1, sel_src2, stall_cycles
   );
endinterface

// File: rtl/exe_hazard_fwd_ctrl.sv
// EXE-stage hazard detection and forwarding-select scheduler: tracks EXE/MEM
// destination records, stalls ID on unresolved RAW, registers operand selects.
module exe_hazard_fwd_ctrl #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   exe_hazard_fwd_ctrl_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dest;
      logic              wb_en;
      logic              mem_r;
   } rec_t;

   localparam logic [1:0]       SEL_RF  = 2'b00;
   localparam logic [1:0]       SEL_MEM = 2'b01;
   localparam logic [1:0]       SEL_WB  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   rec_t             exe_q, exe_d, mem_q, mem_d;
   logic [1:0]       sel1_q, sel1_d, sel2_q, sel2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       m1e_s, m2e_s, m1m_s, m2m_s;
   logic       raw_s, hazard_stall_s, issue_s;
   logic [1:0] nsel1_s, nsel2_s;

   function automatic logic rec_match(input rec_t r, input logic used,
                                      input logic [REG_AW-1:0] src);
      return used & r.valid & r.wb_en & (r.dest == src);
   endfunction

   // Youngest producer (EXE) wins over the older one in MEM.
   function automatic logic [1:0] fwd_sel(input logic fwd_en, input logic m_exe,
                                          input logic m_mem);
      logic [1:0] sel;
      if (!fwd_en) begin
         sel = SEL_RF;
      end else if (m_exe) begin
         sel = SEL_MEM;
      end else if (m_mem) begin
         sel = SEL_WB;
      end else begin
         sel = SEL_RF;
      end
      return sel;
   endfunction

   // Source/record matching, RAW detection and next forwarding selects.
   always_comb begin
      m1e_s = rec_match(exe_q, bus.id_src1_used, bus.id_src1);
      m2e_s = rec_match(exe_q, bus.id_src2_used, bus.id_src2);
      m1m_s = rec_match(mem_q, bus.id_src1_used, bus.id_src1);
      m2m_s = rec_match(mem_q, bus.id_src2_used, bus.id_src2);
      if (bus.forward_en) begin
         raw_s = (m1e_s | m2e_s) & exe_q.mem_r;
      end else begin
         raw_s = m1e_s | m2e_s | m1m_s | m2m_s;
      end
      hazard_stall_s = bus.id_valid & ~bus.flush & raw_s;
      issue_s        = bus.id_valid & ~hazard_stall_s & ~bus.flush;
      nsel1_s        = fwd_sel(bus.forward_en, m1e_s, m1m_s);
      nsel2_s        = fwd_sel(bus.forward_en, m2e_s, m2m_s);
   end

   // Next state: advance the records unless the SRAM freeze holds everything.
   always_comb begin
      exe_d  = exe_q;
      mem_d  = mem_q;
      sel1_d = sel1_q;
      sel2_d = sel2_q;
      cnt_d  = cnt_q;
      if (!bus.mem_freeze) begin
         mem_d = exe_q;
         if (issue_s) begin
            exe_d.valid = 1'b1;
            exe_d.dest  = bus.id_dest;
            exe_d.wb_en = bus.id_wb_en;
            exe_d.mem_r = bus.id_mem_r;
            sel1_d      = nsel1_s;
            sel2_d      = nsel2_s;
         end else begin
            exe_d  = '0;
            sel1_d = SEL_RF;
            sel2_d = SEL_RF;
         end
         if (hazard_stall_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         exe_d  = exe_q;
         mem_d  = mem_q;
         sel1_d = sel1_q;
         sel2_d = sel2_q;
         cnt_d  = cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         exe_q  <= '0;
         mem_q  <= '0;
         sel1_q <= SEL_RF;
         sel2_q <= SEL_RF;
         cnt_q  <= '0;
      end else begin
         exe_q  <= exe_d;
         mem_q  <= mem_d;
         sel1_q <= sel1_d;
         sel2_q <= sel2_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.hazard_stall = hazard_stall_s;
   assign bus.sel_src1     = sel1_q;
   assign bus.sel_src2     = sel2_q;
   assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_exe_hazard_fwd_ctrl.sv
// Scoreboard bench for exe_hazard_fwd_ctrl: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_exe_hazard_fwd_ctrl;

   localparam int REG_AW = 4;
   localparam int CNT_W  = 3;

   typedef struct {
      int         row;
      logic       hz;
      logic [1:0] s1;
      logic [1:0] s2;
      logic [2:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   n_chk;
   int   n_fail;
   int   row_id;
   logic [2:0] ec;

   exe_hazard_fwd_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   exe_hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One vector per cycle: drive inputs just after the edge, queue expectations.
   task automatic row(input logic r, input logic fe, input logic frz, input logic fl,
                      input logic v, input logic [3:0] s1, input logic u1,
                      input logic [3:0] s2, input logic u2, input logic [3:0] d,
                      input logic wb, input logic mr, input logic ehz,
                      input logic [1:0] e1, input logic [1:0] e2, input logic [2:0] ec_i);
      exp_t e;
      @(posedge clk);
      #2;
      rst              = r;
      bus.forward_en   = fe;
      bus.mem_freeze   = frz;
      bus.flush        = fl;
      bus.id_valid     = v;
      bus.id_src1      = s1;
      bus.id_src1_used = u1;
      bus.id_src2      = s2;
      bus.id_src2_used = u2;
      bus.id_dest      = d;
      bus.id_wb_en     = wb;
      bus.id_mem_r     = mr;
      e.row = row_id;
      e.hz  = ehz;
      e.s1  = e1;
      e.s2  = e2;
      e.cnt = ec_i;
      exp_q.push_back(e);
      row_id++;
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk += 4;
         if (bus.hazard_stall !== e.hz) begin
            n_fail++;
            $display("FAIL row %0d hazard_stall: got %b expected %b", e.row, bus.hazard_stall, e.hz);
         end
         if (bus.sel_src1 !== e.s1) begin
            n_fail++;
            $display("FAIL row %0d sel_src1: got %b expected %b", e.row, bus.sel_src1, e.s1);
         end
         if (bus.sel_src2 !== e.s2) begin
            n_fail++;
            $display("FAIL row %0d sel_src2: got %b expected %b", e.row, bus.sel_src2, e.s2);
         end
         if (bus.stall_cycles !== e.cnt) begin
            n_fail++;
            $display("FAIL row %0d stall_cycles: got %0d expected %0d", e.row, bus.stall_cycles, e.cnt);
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      row_id = 1;
      rst = 1'b1;
      bus.forward_en = 1'b1; bus.mem_freeze = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
      bus.id_src1 = 4'd0; bus.id_src1_used = 1'b0; bus.id_src2 = 4'd0; bus.id_src2_used = 1'b0;
      bus.id_dest = 4'd0; bus.id_wb_en = 1'b0; bus.id_mem_r = 1'b0;
      repeat (2) @(posedge clk);

      //   r fe fz fl v  s1 u1 s2 u2 d  wb mr   hz e1 e2 cnt
      row(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset state
      // ADD R1 -> SUB R2,R1,R3 forwarded from MEM-stage ALU result
      row(0, 1, 0, 0, 1, 2, 1, 3, 1, 1, 1, 0,  0, 0, 0, 0);
      row(0, 1, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  0, 0, 0, 0);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
      // ADD R1, EOR R6, ORR R4,R5,R1 forwarded from WB; ADD R1 reads R2 from MEM
      row(0, 1, 0, 0, 1, 2, 1, 3, 1, 1, 1, 0,  0, 0, 0, 0);
      row(0, 1, 0, 0, 1, 7, 1, 8, 1, 6, 1, 0,  0, 2, 0, 0);
      row(0, 1, 0, 0, 1, 5, 1, 1, 1, 4, 1, 0,  0, 0, 0, 0);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0);
      // LDR R1 then ADD R2,R1,R1: one bubble, then WB forwarding on both
      row(0, 1, 0, 0, 1, 2, 1, 0, 0, 1, 1, 1,  0, 0, 0, 0);
      row(0, 1, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 0, 0, 0);
      row(0, 1, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  0, 0, 0, 1);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 1);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
      // forwarding off: two stall cycles, SUB issues with register-file selects
      row(0, 0, 0, 0, 1, 2, 1, 3, 1, 1, 1, 0,  0, 0, 0, 1);
      row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, 1);
      row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, 2);
      row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  0, 0, 0, 3);
      row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
      // ADD R2; LDR R1,[R2] (sel1=01); load-use held by a 3-cycle freeze
      row(0, 1, 0, 0, 1, 5, 1, 6, 1, 2, 1, 0,  0, 0, 0, 3);
      row(0, 1, 0, 0, 1, 2, 1, 0, 0, 1, 1, 1,  0, 0, 0, 3);
      row(0, 1, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 1, 0, 3);
      row(0, 1, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 1, 0, 3);
      row(0, 1, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 1, 0, 3);
      row(0, 1, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 1, 0, 3);
      row(0, 1, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  0, 0, 0, 4);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 4);
      // LDR R3 then flushed ADD R5,R3,R3: no stall, bubble, R5 consumer sees no producer
      row(0, 1, 0, 0, 1, 4, 1, 0, 0, 3, 1, 1,  0, 0, 0, 4);
      row(0, 1, 0, 1, 1, 3, 1, 3, 1, 5, 1, 0,  0, 0, 0, 4);
      row(0, 1, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0,  0, 0, 0, 4);
      // LDR R1,[R6] (sel1=01), then reset with freeze and a load-use pending
      row(0, 1, 0, 0, 1, 6, 1, 0, 0, 1, 1, 1,  0, 0, 0, 4);
      row(1, 1, 1, 0, 1, 1, 1, 1, 1, 2, 1, 0,  1, 1, 0, 4);
      row(0, 1, 0, 0, 1, 1, 1, 1, 1, 2, 1, 0,  0, 0, 0, 0);
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

      // counter saturation: forwarding off, two stalls per dependent pair
      ec = 3'd0;
      for (int i = 0; i < 4; i++) begin
         row(0, 0, 0, 0, 1, 5, 1, 6, 1, 1, 1, 0,  0, 0, 0, ec);
         row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, ec);
         ec = (ec == 3'd7) ? 3'd7 : ec + 3'd1;
         row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  1, 0, 0, ec);
         ec = (ec == 3'd7) ? 3'd7 : ec + 3'd1;
         row(0, 0, 0, 0, 1, 1, 1, 3, 1, 2, 1, 0,  0, 0, 0, ec);
      end
      row(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3'd7);

      repeat (2) @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_hazard_fwd_ctrl.md
Name: exe_hazard_fwd_ctrl

Overview:
- Hazard-detection and forwarding scheduler for the execute stage of the 5-stage ARM-subset pipeline.
- Tracks destination records of instructions in flight in EXE and MEM, and stalls ID on unresolved RAW hazards (load-use, or any RAW when forwarding is off).
- Produces registered operand-source selects for the EXE-stage forwarding muxes: 0 = register-file value, 1 = MEM-stage ALU result, 2 = WB value.
- Sits beside the ID/EXE pipeline register; driven from ID decode, branch-taken flush and SRAM freeze.

Parameters:
- REG_AW, 4, register-address width.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- forward_en  in  1  1 = forwarding enabled; 0 = stall on every RAW.
- mem_freeze  in  1  SRAM busy; freezes all internal state.
- flush  in  1  branch taken in EXE; squashes the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_AW  Rn address.
- id_src1_used  in  1  instruction reads Rn.
- id_src2  in  REG_AW  Rm (or Rd for STR) address.
- id_src2_used  in  1  instruction reads second source.
- id_dest  in  REG_AW  destination address.
- id_wb_en  in  1  instruction writes back.
- id_mem_r  in  1  instruction is a load.
- hazard_stall  out  1  freeze PC/IF-ID and insert a bubble into ID/EXE (combinational).
- sel_src1  out  2  forwarding select for EXE operand 1 (registered).
- sel_src2  out  2  forwarding select for EXE operand 2 (registered).
- stall_cycles  out  CNT_W  saturating count of hazard bubbles inserted.

Behaviour:
- State:
  - exe_rec and mem_rec, each {valid, dest, wb_en, mem_r}.
  - sel_src1_q and sel_src2_q.
  - stall_cycles.
- Reset (rst=1 at a clk edge):
  - Both records are cleared to invalid.
  - sel_src1 = sel_src2 = 2'b00.
  - stall_cycles = 0.
  - hazard_stall is 0 while records are invalid.
- Match rule:
  - matchX(s) = srcK_used & X.valid & X.wb_en & (X.dest == s), for X in {exe_rec, mem_rec}.
- hazard_stall (combinational) = id_valid & ~flush & raw, where:
  - forward_en=1: raw = any used source matching exe_rec while exe_rec.mem_r=1 (load-use only).
  - forward_en=0: raw = any used source matching exe_rec or mem_rec.
- Next-select computation, per source:
  - forward_en=0, or source unused: 00.
  - else matchEXE: 01 (EXE priority, youngest wins).
  - else matchMEM: 10.
  - else 00.
- Advance (mem_freeze=0), at each clk edge:
  - mem_rec <= exe_rec.
  - If id_valid & ~hazard_stall & ~flush: exe_rec <= {1, id_dest, id_wb_en, id_mem_r} and sel_q <= next-selects.
  - Otherwise: exe_rec <= invalid (bubble) and sel_q <= 00.
  - stall_cycles increments when hazard_stall=1; it saturates at all-ones.
- Freeze (mem_freeze=1):
  - Records, sel_q and stall_cycles all hold.
  - hazard_stall is still evaluated (the pipeline is frozen regardless); the counter does not increment.
- Load-use timing: exactly one bubble. Next cycle the load sits in mem_rec, so the dependent instruction issues with sel=10 (WB value).
- Latency: sel outputs are valid in the cycle the instruction occupies EXE, i.e. one edge after issue from ID.
- Register-file write-through for WB-stage producers is handled by the register file; this block does not track WB.
- Simultaneous events:
  - flush dominates hazard_stall; hazard_stall is forced 0 and a bubble is inserted.
  - rst dominates mem_freeze and flush.
- Reset mid-operation: in-flight records are discarded. No forwarding select survives reset.
- Destination R15 gets no special treatment.

Test Plan:
- Reset, then ADD R1 followed by SUB R2,R1,R3 (forward_en=1) -> no stall; at SUB in EXE, sel_src1=01, sel_src2=00.
- ADD R1, unrelated instruction, then ORR R4,R5,R1 -> at ORR in EXE, sel_src2=10, sel_src1=00.
- LDR R1 immediately followed by ADD R2,R1,R1 -> hazard_stall=1 for exactly one cycle; bubble in EXE (sel=00); ADD then in EXE with sel_src1=sel_src2=10; stall_cycles=1.
- forward_en=0, ADD R1 then SUB R2,R1,R3 -> hazard_stall high for 2 cycles, then SUB issues with sel=00; stall_cycles=2.
- Load-use stall while mem_freeze=1 for 3 cycles -> records, sels and stall_cycles unchanged during freeze; then single bubble; counter +1.
- flush=1 in the same cycle as a load-use match -> hazard_stall=0, bubble inserted; rst asserted mid-stream -> next cycle sels=00, counter=0, no stall from prior loads.
